fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding unit.
- Resolves operand sources one cycle early, in ID, and registers the select into EX.
- Detects load-use hazards and inserts one bubble.
- Holds the front end while a multi-cycle EX unit (mul/div) is busy.
- Keeps saturating stall-statistic counters for performance analysis.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (rs1, rs2, ...).
- AW, 5, register address width.
- CNT_W, 16, width of each stall statistic counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  valid instruction in ID.
- id_rs  in  NUM_SRC*AW  source register addresses; source i occupies bits [i*AW +: AW].
- id_rs_used  in  NUM_SRC  per-source "operand actually read" mask.
- ex_rd  in  AW  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  AW  destination register of the instruction in MEM.
- mem_reg_write  in  1  MEM instruction writes the register file.
- mc_start  in  1  EX issues a multi-cycle op this cycle (single-cycle pulse).
- mc_done  in  1  multi-cycle unit result ready (single-cycle pulse).
- clr_cnt  in  1  synchronous clear of the statistic counters.
- fwd_sel  out  2*NUM_SRC  registered select for EX operand i, bits [2i+1:2i].
- stall_id  out  1  hold PC and the IF/ID register.
- flush_ex  out  1  load a bubble into ID/EX.
- mc_busy  out  1  FSM is in MC_BUSY.
- ld_stall_cnt  out  CNT_W  count of load-use stall cycles.
- mc_stall_cnt  out  CNT_W  count of multi-cycle stall cycles.

Behaviour:
- Select encoding:
  - 00: register file. The register file is write-first, so the WB-stage write is visible to ID in the same cycle.
  - 10: forward from the MEM-stage result.
  - 01: forward from the WB-stage result.
- Next-select computation in ID, per source i, with a match requiring id_valid and id_rs_used[i]:
  - If ex_reg_write, ex_rd != 0 and ex_rd == rs_i: next select is 10 (the producer will be in MEM next cycle).
  - Else if mem_reg_write, mem_rd != 0 and mem_rd == rs_i: next select is 01.
  - Else: next select is 00.
  - MEM takes priority over WB. Register 0 never forwards.
- Load-use hazard:
  - Condition: ex_mem_read and ex_reg_write and ex_rd != 0, and ex_rd matches any used source of a valid ID instruction.
- FSM states RUN and MC_BUSY. Reset value is RUN.
- In RUN:
  - Load-use hazard present: stall_id = 1, flush_ex = 1, and fwd_sel is loaded with all 00 (the bubble). The next cycle re-evaluates; the load is then in MEM, so the select resolves to 01.
  - Otherwise, with mc_start = 0: stall_id = 0, flush_ex = 0, and fwd_sel is loaded with the next-select value.
  - mc_start = 1: go to MC_BUSY. The ID instruction is held (stall_id = 1) and fwd_sel is held.
  - mc_start takes precedence over a simultaneous load-use hazard. The EX instruction cannot be both a load and a multi-cycle op.
- In MC_BUSY:
  - stall_id = 1, flush_ex = 0, fwd_sel held.
  - The multi-cycle unit latched its operands at mc_start, so stale selects are harmless.
  - On mc_done: return to RUN the next cycle. In the mc_done cycle itself, stall_id is still asserted and fwd_sel is reloaded with the next-select value.
  - mc_done while in RUN is ignored.
  - mc_start while in MC_BUSY is ignored.
- mc_busy = 1 exactly when the state is MC_BUSY.
- Counters:
  - ld_stall_cnt increments on every cycle with a load-use stall.
  - mc_stall_cnt increments on every cycle in MC_BUSY, including the entry cycle in RUN where mc_start = 1.
  - Both saturate at all-ones.
  - clr_cnt zeroes both counters and takes priority over increment.
- Reset:
  - Asynchronous assertion forces the FSM to RUN, fwd_sel = 0 and counters = 0 immediately, including mid-MC_BUSY.
  - stall_id and flush_ex are combinational from state and inputs. While in reset they are driven 0.
- Latency: the select computed from ID inputs appears on fwd_sel one cycle later, aligned with the instruction entering EX.

Decomposition:
- Shared package fwd_pkg holds:
  - select encoding constants FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10;
  - the state enum (RUN, MC_BUSY).
- One sub-module, fwd_src_sel: the combinational per-source comparator producing the next select and a hazard bit. Instantiate it NUM_SRC times with a generate loop.
- The FSM, select registers and counters live in the top level.

Test Plan:
- ALU dependency: ex_rd = 5 with reg_write, id_rs[0] = 5 used, id_rs[1] = 6 -> next cycle fwd_sel[1:0] = 10, fwd_sel[3:2] = 00; no stall.
- Double producer: ex_rd = 7 and mem_rd = 7 both writing, id_rs[1] = 7 -> fwd_sel[3:2] = 10 (MEM priority). Repeat with rd = 0 -> 00.
- Load-use on rs2: ex_mem_read with ex_rd = 9, id_rs[1] = 9 -> one cycle with stall_id = 1, flush_ex = 1, fwd_sel = 0. Next cycle (load in MEM as mem_rd = 9) -> fwd_sel[3:2] = 01, ld_stall_cnt = 1.
- Unused-source filter: same load-use setup but id_rs_used[1] = 0 -> no stall.
- Multi-cycle op: mc_start, then mc_done after 4 cycles -> stall_id high for 5 cycles, mc_busy high for 4 cycles, mc_stall_cnt = 5.
- Reset and saturation:
  - Assert rst_n low mid-MC_BUSY -> mc_busy, stall_id, fwd_sel and counters all read 0 immediately.
  - With CNT_W = 2, 5 load stalls -> ld_stall_cnt = 3; clr_cnt -> 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings for the ID-stage forwarding / hazard unit.
package fwd_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } fsm_state_e;
endpackage

// File: rtl/fwd_src_sel.sv
// Per-source comparator: next forwarding select and load-use hazard bit for one operand.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          id_valid_i,
    input  logic [AW-1:0] rs_i,
    input  logic          used_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          ex_reg_write_i,
    input  logic          ex_mem_read_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic          mem_reg_write_i,
    output logic [1:0]    nsel_o,
    output logic          hazard_o
);
    logic rd_match_ex, rd_match_mem;

    // Register 0 is hardwired, so it never matches a producer.
    assign rd_match_ex  = id_valid_i && used_i && ex_reg_write_i &&
                          (ex_rd_i != '0) && (ex_rd_i == rs_i);
    assign rd_match_mem = id_valid_i && used_i && mem_reg_write_i &&
                          (mem_rd_i != '0) && (mem_rd_i == rs_i);

    // The EX producer moves to MEM next cycle, so it outranks the older MEM producer.
    assign nsel_o   = rd_match_ex  ? FWD_MEM :
                      rd_match_mem ? FWD_WB  : FWD_RF;
    assign hazard_o = rd_match_ex && ex_mem_read_i;
endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding select, load-use bubble, multi-cycle hold FSM and stall counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [AW-1:0]          ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic [AW-1:0]          mem_rd,
    input  logic                   mem_reg_write,
    input  logic                   mc_start,
    input  logic                   mc_done,
    input  logic                   clr_cnt,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   stall_id,
    output logic                   flush_ex,
    output logic                   mc_busy,
    output logic [CNT_W-1:0]       ld_stall_cnt,
    output logic [CNT_W-1:0]       mc_stall_cnt
);
    logic [NUM_SRC-1:0][1:0] nsel_w;
    logic [NUM_SRC-1:0]      haz_w;
    logic                    load_use;

    fsm_state_e              state_q, state_d;
    logic [2*NUM_SRC-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]        ld_cnt_q, ld_cnt_d, mc_cnt_q, mc_cnt_d;
    logic                    stall_c, flush_c, ld_inc, mc_inc;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_sel #(.AW(AW)) u_src (
            .id_valid_i      (id_valid),
            .rs_i            (id_rs[g*AW +: AW]),
            .used_i          (id_rs_used[g]),
            .ex_rd_i         (ex_rd),
            .ex_reg_write_i  (ex_reg_write),
            .ex_mem_read_i   (ex_mem_read),
            .mem_rd_i        (mem_rd),
            .mem_reg_write_i (mem_reg_write),
            .nsel_o          (nsel_w[g]),
            .hazard_o        (haz_w[g])
        );
    end

    assign load_use = |haz_w;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        stall_c = 1'b0;
        flush_c = 1'b0;
        ld_inc  = 1'b0;
        mc_inc  = 1'b0;
        unique case (state_q)
            RUN: begin
                // A multi-cycle issue wins over a load-use hazard; both cannot be real at once.
                if (mc_start) begin
                    state_d = MC_BUSY;
                    stall_c = 1'b1;
                    mc_inc  = 1'b1;
                end else if (load_use) begin
                    stall_c = 1'b1;
                    flush_c = 1'b1;
                    ld_inc  = 1'b1;
                    sel_d   = '0;
                end else begin
                    sel_d   = nsel_w;
                end
            end
            MC_BUSY: begin
                stall_c = 1'b1;
                mc_inc  = 1'b1;
                if (mc_done) begin
                    state_d = RUN;
                    sel_d   = nsel_w;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        mc_cnt_d = mc_cnt_q;
        if (clr_cnt) begin
            ld_cnt_d = '0;
            mc_cnt_d = '0;
        end else begin
            if (ld_inc && (ld_cnt_q != '1)) ld_cnt_d = ld_cnt_q + CNT_W'(1);
            if (mc_inc && (mc_cnt_q != '1)) mc_cnt_d = mc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            sel_q    <= '0;
            ld_cnt_q <= '0;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ld_cnt_q <= ld_cnt_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Hold/flush are combinational, so force them quiet while reset is asserted.
    assign stall_id     = rst_n & stall_c;
    assign flush_ex     = rst_n & flush_c;
    assign mc_busy      = (state_q == MC_BUSY);
    assign fwd_sel      = sel_q;
    assign ld_stall_cnt = ld_cnt_q;
    assign mc_stall_cnt = mc_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Random + directed bench for fwd_hazard_unit against a cycle-level reference model.
module tb_fwd_hazard_unit;
    localparam int NUM_SRC = 2;
    localparam int AW      = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  id_valid;
    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [AW-1:0]         ex_rd, mem_rd;
    logic                  ex_reg_write, ex_mem_read, mem_reg_write;
    logic                  mc_start, mc_done, clr_cnt;

    logic [2*NUM_SRC-1:0]  fwd_sel, fwd_sel_s;
    logic                  stall_id, flush_ex, mc_busy;
    logic                  stall_id_s, flush_ex_s, mc_busy_s;
    logic [15:0]           ld_cnt, mc_cnt;
    logic [1:0]            ld_cnt_s, mc_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_busy;
    int m_sel [NUM_SRC];
    int m_ld, m_mc;
    int obs_stall, obs_busy;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mc_start(mc_start), .mc_done(mc_done),
        .clr_cnt(clr_cnt), .fwd_sel(fwd_sel), .stall_id(stall_id), .flush_ex(flush_ex),
        .mc_busy(mc_busy), .ld_stall_cnt(ld_cnt), .mc_stall_cnt(mc_cnt));

    fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mc_start(mc_start), .mc_done(mc_done),
        .clr_cnt(clr_cnt), .fwd_sel(fwd_sel_s), .stall_id(stall_id_s), .flush_ex(flush_ex_s),
        .mc_busy(mc_busy_s), .ld_stall_cnt(ld_cnt_s), .mc_stall_cnt(mc_cnt_s));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rs_of(int i);
        return int'(id_rs[i*AW +: AW]);
    endfunction

    // Where source i should come from next cycle, straight from the forwarding rules.
    function automatic int want_sel(int i);
        if (!id_valid || !id_rs_used[i]) return 0;
        if (ex_reg_write && ex_rd != 0 && int'(ex_rd) == rs_of(i)) return 2;
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs_of(i)) return 1;
        return 0;
    endfunction

    function automatic bit load_use();
        bit hit = 0;
        for (int i = 0; i < NUM_SRC; i++)
            if (id_valid && id_rs_used[i] && int'(ex_rd) == rs_of(i)) hit = 1;
        return hit && ex_mem_read && ex_reg_write && ex_rd != 0;
    endfunction

    function automatic int sel_word();
        int w = 0;
        for (int i = 0; i < NUM_SRC; i++) w += m_sel[i] << (2*i);
        return w;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ld = 0; m_mc = 0;
        for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rs_used = '0;
        ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = '0; mem_reg_write = 0;
        mc_start = 0; mc_done = 0; clr_cnt = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".sel"},    int'(fwd_sel),   sel_word());
        chk({tag, ".sel_s"},  int'(fwd_sel_s), sel_word());
        chk({tag, ".busy"},   int'(mc_busy),   m_busy);
        chk({tag, ".busy_s"}, int'(mc_busy_s), m_busy);
        chk({tag, ".ld"},     int'(ld_cnt),    sat(m_ld, 65535));
        chk({tag, ".mc"},     int'(mc_cnt),    sat(m_mc, 65535));
        chk({tag, ".ld_s"},   int'(ld_cnt_s),  sat(m_ld, 3));
        chk({tag, ".mc_s"},   int'(mc_cnt_s),  sat(m_mc, 3));
    endtask

    // Inputs are set just after a negedge; this checks and advances one cycle, ending at the next negedge.
    task automatic tick(input string tag);
        int  nxt [NUM_SRC];
        bit  hz;
        int  e_stall, e_flush, ld_i, mc_i;
        #1;
        for (int i = 0; i < NUM_SRC; i++) nxt[i] = want_sel(i);
        hz = load_use();
        e_stall = 0; e_flush = 0; ld_i = 0; mc_i = 0;
        if (m_busy == 0) begin
            if (mc_start) begin
                e_stall = 1; mc_i = 1; m_busy = 1;
            end else if (hz) begin
                e_stall = 1; e_flush = 1; ld_i = 1;
                for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) m_sel[i] = nxt[i];
            end
        end else begin
            e_stall = 1; mc_i = 1;
            if (mc_done) begin
                m_busy = 0;
                for (int i = 0; i < NUM_SRC; i++) m_sel[i] = nxt[i];
            end
        end
        chk({tag, ".stall"},   int'(stall_id),   e_stall);
        chk({tag, ".flush"},   int'(flush_ex),   e_flush);
        chk({tag, ".stall_s"}, int'(stall_id_s), e_stall);
        chk({tag, ".flush_s"}, int'(flush_ex_s), e_flush);
        obs_stall += int'(stall_id);
        if (clr_cnt) begin
            m_ld = 0; m_mc = 0;
        end else begin
            m_ld += ld_i; m_mc += mc_i;
        end
        @(posedge clk);
        #1;
        obs_busy += int'(mc_busy);
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        id_valid = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < NUM_SRC; i++) id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
        id_rs_used    = NUM_SRC'($urandom);
        ex_rd         = AW'($urandom_range(0, 7));
        ex_reg_write  = $urandom_range(0, 1) == 1;
        ex_mem_read   = $urandom_range(0, 3) == 0;
        mem_rd        = AW'($urandom_range(0, 7));
        mem_reg_write = $urandom_range(0, 1) == 1;
        mc_start      = $urandom_range(0, 19) == 0;
        if (mc_start) ex_mem_read = 0;
        mc_done       = $urandom_range(0, 5) == 0;
        clr_cnt       = $urandom_range(0, 99) == 0;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        #3;
        check_regs("reset");
        chk("reset.stall", int'(stall_id), 0);
        chk("reset.flush", int'(flush_ex), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // ALU dependency on rs1
        idle();
        id_valid = 1; id_rs_used = 2'b11;
        id_rs[0 +: AW] = 5'd5; id_rs[AW +: AW] = 5'd6;
        ex_rd = 5'd5; ex_reg_write = 1;
        tick("alu");
        chk("alu.sel_const", int'(fwd_sel), 4'b0010);

        // both producers hit rs2: MEM select wins
        idle();
        id_valid = 1; id_rs_used = 2'b11; id_rs[AW +: AW] = 5'd7;
        ex_rd = 5'd7; ex_reg_write = 1; mem_rd = 5'd7; mem_reg_write = 1;
        tick("dbl");
        chk("dbl.sel_const", int'(fwd_sel[3:2]), 2);
        id_rs[AW +: AW] = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        tick("dbl0");
        chk("dbl0.sel_const", int'(fwd_sel[3:2]), 0);

        // load-use on rs2, then the load sits in MEM
        idle();
        id_valid = 1; id_rs_used = 2'b11; id_rs[AW +: AW] = 5'd9;
        ex_rd = 5'd9; ex_reg_write = 1; ex_mem_read = 1;
        tick("ldu");
        chk("ldu.sel_const", int'(fwd_sel), 0);
        ex_rd = 5'd0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 5'd9; mem_reg_write = 1;
        tick("ldu2");
        chk("ldu2.sel_const", int'(fwd_sel[3:2]), 1);
        chk("ldu2.cnt_const", int'(ld_cnt), 1);

        // same load but rs2 not read: no bubble
        idle();
        id_valid = 1; id_rs_used = 2'b01; id_rs[AW +: AW] = 5'd9;
        ex_rd = 5'd9; ex_reg_write = 1; ex_mem_read = 1;
        tick("unused");

        // multi-cycle op, done four cycles after issue
        idle();
        obs_stall = 0; obs_busy = 0;
        mc_start = 1;
        tick("mc0");
        mc_start = 0;
        for (int c = 1; c <= 4; c++) begin
            mc_done = (c == 4);
            tick("mc");
        end
        mc_done = 0;
        tick("mc_end");
        chk("mc.stall_cycles", obs_stall, 5);
        chk("mc.busy_cycles", obs_busy, 4);
        chk("mc.cnt_const", int'(mc_cnt), 5);

        // saturation on the 2-bit instance, then clear
        idle();
        clr_cnt = 1;
        tick("clr");
        clr_cnt = 0;
        id_valid = 1; id_rs_used = 2'b01; id_rs[0 +: AW] = 5'd3;
        ex_rd = 5'd3; ex_reg_write = 1; ex_mem_read = 1;
        for (int c = 0; c < 5; c++) tick("sat");
        chk("sat.ld_s_const", int'(ld_cnt_s), 3);
        chk("sat.ld_const", int'(ld_cnt), 5);
        idle();
        clr_cnt = 1;
        tick("clr2");
        chk("clr2.ld_s_const", int'(ld_cnt_s), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            tick("rnd");
        end

        // async reset in the middle of a multi-cycle hold
        idle();
        if (m_busy != 0) begin
            mc_done = 1;
            tick("drain");
            idle();
        end
        mc_start = 1;
        tick("mcr0");
        mc_start = 0;
        tick("mcr1");
        chk("mcr.busy_before", int'(mc_busy), 1);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("arst.busy",  int'(mc_busy),  0);
        chk("arst.stall", int'(stall_id), 0);
        check_regs("arst");
        @(negedge clk);
        rst_n = 1;
        tick("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
